// File: rtl/ram_req_arbiter.sv
// Round-robin arbiter and mv/moc sequencer that shares one 256x8 RAM between fetch (port 0) and data (port 1).
// Optional build macro RAMCTRL_MOC_TIMEOUT_EN adds a WAIT-state moc timeout of TIMEOUT_CYCLES cycles.
//
// state | meaning
// IDLE  | arbitrate, latch winner, range check
// ISSUE | mem_mv asserted with latched access
// WAIT  | hold access until mem_moc (or timeout)
// RESP  | one-cycle done pulse, err/rdata valid
// DRAIN | wait for mem_moc to fall
module ram_req_arbiter #(
  parameter int AW             = 8,
  parameter int DW             = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic [1:0]      req_rw,
  input  logic [2*AW-1:0] req_addr,
  input  logic [3:0]      req_size,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      done,
  output logic            err,
  output logic [DW-1:0]   rdata,
  output logic            mem_mv,
  output logic            mem_rw,
  output logic [AW-1:0]   mem_addr,
  output logic [1:0]      mem_type,
  output logic [DW-1:0]   mem_din,
  input  logic [DW-1:0]   mem_dout,
  input  logic            mem_moc
);

  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            ptr, ptr_nxt;
  logic            gnt, gnt_nxt;
  logic [1:0]      done_nxt;
  logic            err_nxt;
  logic [DW-1:0]   rdata_nxt;
  logic            mv_nxt;
  logic            rw_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [1:0]      type_nxt;
  logic [DW-1:0]   din_nxt;

  logic            win;
  logic            win_rw;
  logic [AW-1:0]   win_addr;
  logic [1:0]      win_size;
  logic [DW-1:0]   win_wdata;
  logic [2:0]      span;
  logic [AW:0]     last_byte;
  logic            out_of_range;

`ifdef RAMCTRL_MOC_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0]   tmr, tmr_nxt;
  logic            timed_out, timed_out_nxt;
`endif

  // Contention goes to the pointer port; a lone requester always wins.
  always_comb begin
    win       = (req == 2'b11) ? ptr : req[1];
    win_rw    = win ? req_rw[1] : req_rw[0];
    win_addr  = win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    win_size  = win ? req_size[3:2] : req_size[1:0];
    win_wdata = win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    span      = {&win_size, win_size[1], |win_size};
    last_byte = {1'b0, win_addr} + (AW+1)'(span);
    out_of_range = last_byte[AW];
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    done_nxt  = 2'b00;
    err_nxt   = 1'b0;
    rdata_nxt = rdata;
    mv_nxt    = mem_mv;
    rw_nxt    = mem_rw;
    addr_nxt  = mem_addr;
    type_nxt  = mem_type;
    din_nxt   = mem_din;
`ifdef RAMCTRL_MOC_TIMEOUT_EN
    tmr_nxt       = tmr;
    timed_out_nxt = timed_out;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt = win;
          ptr_nxt = ~win;
          if (out_of_range) begin
            state_nxt = RESP;
            done_nxt  = win ? 2'b10 : 2'b01;
            err_nxt   = 1'b1;
            rdata_nxt = '0;
          end else begin
            state_nxt = ISSUE;
            mv_nxt    = 1'b1;
            rw_nxt    = win_rw;
            addr_nxt  = win_addr;
            type_nxt  = win_size;
            din_nxt   = win_wdata;
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
`ifdef RAMCTRL_MOC_TIMEOUT_EN
        tmr_nxt       = TMR_LOAD;
        timed_out_nxt = 1'b0;
`endif
      end
      WAIT: begin
        if (mem_moc) begin
          state_nxt = RESP;
          mv_nxt    = 1'b0;
          done_nxt  = gnt ? 2'b10 : 2'b01;
          if (mem_rw) rdata_nxt = mem_dout;
        end
`ifdef RAMCTRL_MOC_TIMEOUT_EN
        else if (tmr == '0) begin
          state_nxt     = RESP;
          mv_nxt        = 1'b0;
          done_nxt      = gnt ? 2'b10 : 2'b01;
          err_nxt       = 1'b1;
          timed_out_nxt = 1'b1;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
`endif
      end
      RESP: begin
`ifdef RAMCTRL_MOC_TIMEOUT_EN
        state_nxt = timed_out ? IDLE : DRAIN;
`else
        state_nxt = DRAIN;
`endif
      end
      DRAIN: begin
        if (!mem_moc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      done     <= 2'b00;
      err      <= 1'b0;
      rdata    <= '0;
      mem_mv   <= 1'b0;
      mem_rw   <= 1'b1;
      mem_addr <= '0;
      mem_type <= 2'b00;
      mem_din  <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      rdata    <= rdata_nxt;
      mem_mv   <= mv_nxt;
      mem_rw   <= rw_nxt;
      mem_addr <= addr_nxt;
      mem_type <= type_nxt;
      mem_din  <= din_nxt;
    end
  end

`ifdef RAMCTRL_MOC_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr       <= '0;
      timed_out <= 1'b0;
    end else begin
      tmr       <= tmr_nxt;
      timed_out <= timed_out_nxt;
    end
  end
`endif

endmodule
